// File: rtl/gpr_pkg.sv
// Shared GPR writeback definitions: widths, default depth and the queued entry layout.
package gpr_pkg;

    localparam int GPR_DW       = 32;
    localparam int GPR_AW       = 5;
    localparam int GPR_WB_DEPTH = 4;

    // "reg" is a keyword, so the register-number field is named rnum.
    typedef struct packed {
        logic [GPR_AW-1:0] rnum;
        logic [GPR_DW-1:0] data;
    } gpr_wb_entry_t;

    function automatic gpr_wb_entry_t gpr_wb_pack(input logic [GPR_AW-1:0] rnum,
                                                  input logic [GPR_DW-1:0] data);
        gpr_wb_entry_t e;
        e.rnum = rnum;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/gpr_wb_fifo.sv
// Circular entry store with read/write pointers; exposes every slot so the
// parent can run bypass lookups without a second read port.
module gpr_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int EW    = 37
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          i_push,
    input  logic [EW-1:0]                 i_wdata,
    input  logic                          i_pop,
    output logic [EW-1:0]                 o_head,
    output logic [$clog2(DEPTH):0]        o_count,
    output logic [$clog2(DEPTH)-1:0]      o_rd_ptr,
    output logic [DEPTH-1:0][EW-1:0]      o_mem
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][EW-1:0] r_mem;
    logic [PW-1:0]            r_wr_ptr;
    logic [PW-1:0]            r_rd_ptr;
    logic [CW-1:0]            r_count;

    // Pointers are exactly log2(DEPTH) wide, so increment wraps modulo DEPTH.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (i_push && !RST) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_head   = r_mem[r_rd_ptr];
    assign o_count  = r_count;
    assign o_rd_ptr = r_rd_ptr;
    assign o_mem    = r_mem;

endmodule

// File: rtl/gpr_wb_queue.sv
// In-order GPR writeback queue with registered drain port and optional bypass.
// Bypass lookup is compiled in only when GPR_WB_BYPASS_EN is defined.
import gpr_pkg::*;

module gpr_wb_queue #(
    parameter int DEPTH = GPR_WB_DEPTH,
    parameter int DW    = GPR_DW
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [GPR_AW-1:0]        in_reg,
    input  logic [DW-1:0]            in_data,
    input  logic                     HOLD,
    output logic                     GPRWr,
    output logic [GPR_AW-1:0]        W_Reg,
    output logic [DW-1:0]            W_data,
    input  logic [GPR_AW-1:0]        Q_Reg,
    output logic                     Q_hit,
    output logic [DW-1:0]            Q_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = GPR_AW + DW;

    logic [EW-1:0]            w_head;
    logic [CW-1:0]            w_count;
    logic [PW-1:0]            w_rd_ptr;
    logic [DEPTH-1:0][EW-1:0] w_mem;
    logic                     w_push;
    logic                     w_pop;

    logic                     r_gprwr;
    logic [GPR_AW-1:0]        r_wreg;
    logic [DW-1:0]            r_wdata;

    // Full refuses input even when a drain happens the same cycle.
    assign in_ready = (w_count != CW'(DEPTH));
    // r0 writes complete the handshake but are silently dropped.
    assign w_push   = in_valid && in_ready && (in_reg != '0);
    assign w_pop    = (w_count != '0) && !HOLD;

    gpr_wb_fifo #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .i_push   (w_push),
        .i_wdata  ({in_reg, in_data}),
        .i_pop    (w_pop),
        .o_head   (w_head),
        .o_count  (w_count),
        .o_rd_ptr (w_rd_ptr),
        .o_mem    (w_mem)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_gprwr <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
        end else if (w_pop) begin
            r_gprwr <= 1'b1;
            r_wreg  <= w_head[EW-1 -: GPR_AW];
            r_wdata <= w_head[DW-1:0];
        end else begin
            r_gprwr <= 1'b0;
        end
    end

    assign GPRWr  = r_gprwr;
    assign W_Reg  = r_wreg;
    assign W_data = r_wdata;
    assign count  = w_count;

`ifdef GPR_WB_BYPASS_EN
    logic          w_q_hit;
    logic [DW-1:0] w_q_data;

    // Scan oldest to newest (drain register, then head onward) so the last match wins.
    always_comb begin
        w_q_hit  = 1'b0;
        w_q_data = '0;
        if (Q_Reg != '0) begin
            if (r_gprwr && (r_wreg == Q_Reg)) begin
                w_q_hit  = 1'b1;
                w_q_data = r_wdata;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if ((CW'(i) < w_count) &&
                    (w_mem[PW'(w_rd_ptr + PW'(i))][EW-1 -: GPR_AW] == Q_Reg)) begin
                    w_q_hit  = 1'b1;
                    w_q_data = w_mem[PW'(w_rd_ptr + PW'(i))][DW-1:0];
                end
            end
        end
    end

    assign Q_hit  = w_q_hit;
    assign Q_data = w_q_data;
`else
    logic w_unused_bypass;
    assign w_unused_bypass = ^{Q_Reg, w_rd_ptr, w_mem};
    assign Q_hit  = 1'b0;
    assign Q_data = '0;
`endif

endmodule
